note_player_seq: RTL and testbench

Parametrised successor to the song player's note-sequencing FSM. Accepts notes with a per-note beat duration into a one-entry pending buffer, plays them back-to-back against an external beat tick, and pulses `note_done` at each note boundary. The internal duration counter replaces the external timer handshake (`timer_clear`/`timer_done`). Rest notes are supported. Sits between the song reader and the frequency/codec stage.

---
 rtl/note_player_seq.sv | 115 +++++++++++
 tb/tb_note_player_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_player_seq.sv
// Note sequencer: one-entry pending buffer, beat-counted playback, note_done at each boundary.
// Optional `NOTE_PLAYER_PAUSE_EN: play_enable low pauses the current note instead of aborting it.
module note_player_seq #(
    parameter int unsigned NOTE_WIDTH = 6,
    parameter int unsigned DUR_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  beat,
    input  logic                  load_new_note,
    input  logic [NOTE_WIDTH-1:0] new_note,
    input  logic [DUR_WIDTH-1:0]  new_duration,
    output logic [NOTE_WIDTH-1:0] note_out,
    output logic                  note_active,
    output logic [DUR_WIDTH-1:0]  beats_left,
    output logic                  note_done,
    output logic                  buf_full,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [NOTE_WIDTH-1:0] r_note_out;
    logic [DUR_WIDTH-1:0]  r_beats_left;
    logic                  r_note_done;
    logic                  r_buf_full;
    logic [NOTE_WIDTH-1:0] r_buf_note;
    logic [DUR_WIDTH-1:0]  r_buf_dur;
    logic                  r_overrun;

    logic                  w_accept;
    logic [DUR_WIDTH-1:0]  w_load_dur;

    // The buffer is writable when empty or while LOAD is draining it this cycle.
    assign w_accept   = load_new_note && (!r_buf_full || (r_state == S_LOAD));
    assign w_load_dur = (r_buf_dur == '0) ? DUR_WIDTH'(1) : r_buf_dur;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_note_out   <= '0;
            r_beats_left <= '0;
            r_note_done  <= 1'b0;
            r_buf_full   <= 1'b0;
            r_buf_note   <= '0;
            r_buf_dur    <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_note_done <= 1'b0;
            r_overrun   <= load_new_note && !w_accept;

            if (w_accept) begin
                r_buf_note <= new_note;
                r_buf_dur  <= new_duration;
                r_buf_full <= 1'b1;
            end else if (r_state == S_LOAD) begin
                r_buf_full <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (play_enable && r_buf_full) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_note_out   <= r_buf_note;
                    r_beats_left <= w_load_dur;
                    r_state      <= S_PLAY;
                end
                S_PLAY: begin
                    if (play_enable) begin
                        if (beat) begin
                            if (r_beats_left == DUR_WIDTH'(1)) begin
                                r_state     <= S_DONE;
                                r_note_done <= 1'b1;
                            end else begin
                                r_beats_left <= r_beats_left - DUR_WIDTH'(1);
                            end
                        end
                    end else begin
`ifdef NOTE_PLAYER_PAUSE_EN
                        r_state <= S_PLAY;
`else
                        r_state      <= S_IDLE;
                        r_beats_left <= '0;
`endif
                    end
                end
                S_DONE: begin
                    r_beats_left <= '0;
                    r_state      <= (play_enable && r_buf_full) ? S_LOAD : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign note_out    = r_note_out;
    assign beats_left  = r_beats_left;
    assign note_done   = r_note_done;
    assign buf_full    = r_buf_full;
    assign overrun     = r_overrun;
    assign note_active = (r_state == S_PLAY) && play_enable && (r_note_out != '0);

endmodule

// File: tb/tb_note_player_seq.sv
// Bench for note_player_seq: directed scenarios then random traffic against a queue-based model.
module tb_note_player_seq;

    localparam int unsigned NW = 6;
    localparam int unsigned DW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          play_enable;
    logic          beat;
    logic          load_new_note;
    logic [NW-1:0] new_note;
    logic [DW-1:0] new_duration;
    logic [NW-1:0] note_out;
    logic          note_active;
    logic [DW-1:0] beats_left;
    logic          note_done;
    logic          buf_full;
    logic          overrun;

    note_player_seq #(.NOTE_WIDTH(NW), .DUR_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .play_enable  (play_enable),
        .beat         (beat),
        .load_new_note(load_new_note),
        .new_note     (new_note),
        .new_duration (new_duration),
        .note_out     (note_out),
        .note_active  (note_active),
        .beats_left   (beats_left),
        .note_done    (note_done),
        .buf_full     (buf_full),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt;

    // Reference: phase of the player, current note, remaining beats, pending notes as queues.
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_PLAY = 2, PH_DONE = 3;
    int m_phase = PH_IDLE;
    int m_cur   = 0;
    int m_left  = 0;
    int m_done  = 0;
    int m_ovr   = 0;
    int q_note[$];
    int q_dur[$];

    task automatic model_step();
        bit take;
        if (reset) begin
            m_phase = PH_IDLE; m_cur = 0; m_left = 0; m_done = 0; m_ovr = 0;
            q_note.delete(); q_dur.delete();
            return;
        end
        take   = load_new_note && (q_note.size() == 0 || m_phase == PH_LOAD);
        m_ovr  = (load_new_note && !take) ? 1 : 0;
        m_done = 0;
        case (m_phase)
            PH_IDLE: if (play_enable && q_note.size() > 0) m_phase = PH_LOAD;
            PH_LOAD: begin
                m_cur  = q_note.pop_front();
                m_left = q_dur.pop_front();
                if (m_left == 0) m_left = 1;
                m_phase = PH_PLAY;
            end
            PH_PLAY: begin
                if (play_enable) begin
                    if (beat) begin
                        if (m_left == 1) begin m_phase = PH_DONE; m_done = 1; end
                        else m_left = m_left - 1;
                    end
                end else begin
`ifdef NOTE_PLAYER_PAUSE_EN
                    m_phase = PH_PLAY;
`else
                    m_phase = PH_IDLE; m_left = 0;
`endif
                end
            end
            default: begin
                m_left  = 0;
                m_phase = (play_enable && q_note.size() > 0) ? PH_LOAD : PH_IDLE;
            end
        endcase
        if (take) begin
            q_note.push_back(int'(new_note));
            q_dur.push_back(int'(new_duration));
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === 32'(exp)) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        int exp_active;
        exp_active = (m_phase == PH_PLAY && play_enable && m_cur != 0) ? 1 : 0;
        check("note_out",    32'(note_out),    m_cur);
        check("beats_left",  32'(beats_left),  m_left);
        check("note_done",   32'(note_done),   m_done);
        check("buf_full",    32'(buf_full),    (q_note.size() > 0) ? 1 : 0);
        check("overrun",     32'(overrun),     m_ovr);
        check("note_active", 32'(note_active), exp_active);
    endtask

    // Advance one edge, update the model, compare #1 later, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (note_done === 1'b1) done_cnt++;
        @(negedge clk);
    endtask

    task automatic load(input int n, input int d);
        load_new_note = 1'b1;
        new_note      = NW'(n);
        new_duration  = DW'(d);
        tick();
        load_new_note = 1'b0;
    endtask

    task automatic run(input int cycles, input int period);
        for (int i = 0; i < cycles; i++) begin
            beat = ((i % period) == period - 1);
            tick();
        end
        beat = 1'b0;
    endtask

    initial begin
        reset = 1'b1; play_enable = 1'b1; beat = 1'b0;
        load_new_note = 1'b0; new_note = '0; new_duration = '0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check("rst_note_out", 32'(note_out), 0);
        check("rst_buf_full", 32'(buf_full), 0);

        // Basic playback: note 5, 3 beats
        load(5, 3);
        tick();
        tick();
        check("basic_active", 32'(note_active), 1);
        check("basic_beats",  32'(beats_left), 3);
        done_cnt = 0;
        run(20, 4);
        check("basic_done_cnt", 32'(done_cnt), 1);
        check("basic_idle_note", 32'(note_out), 5);
        check("basic_idle_active", 32'(note_active), 0);

        // Gapless into a rest note
        load(7, 2);
        tick();
        tick();
        done_cnt = 0;
        load(0, 1);
        run(30, 3);
        check("gapless_done_cnt", 32'(done_cnt), 2);
        check("rest_note_out", 32'(note_out), 0);

        // Overrun while buffer full
        load(9, 3);
        tick();
        tick();
        done_cnt = 0;
        load(10, 2);
        load(11, 1);
        check("overrun_pulse", 32'(overrun), 1);
        tick();
        check("overrun_clear", 32'(overrun), 0);
        run(40, 2);
        check("overrun_done_cnt", 32'(done_cnt), 2);
        check("overrun_kept_note", 32'(note_out), 10);

        // Refill during LOAD
        load(20, 1);
        tick();
        done_cnt = 0;
        load(21, 2);
        check("refill_buf_full", 32'(buf_full), 1);
        tick();
        check("refill_no_ovr", 32'(overrun), 0);
        run(30, 2);
        check("refill_done_cnt", 32'(done_cnt), 2);
        check("refill_note", 32'(note_out), 21);

        // Duration zero plays one beat
        load(3, 0);
        tick();
        tick();
        check("dur0_beats", 32'(beats_left), 1);
        done_cnt = 0;
        run(20, 5);
        check("dur0_done_cnt", 32'(done_cnt), 1);

        // play_enable low mid-note with a pending note
        load(30, 4);
        tick();
        tick();
        beat = 1'b1; tick(); beat = 1'b0; tick();
        beat = 1'b1; tick(); beat = 1'b0;
        check("pause_pre_beats", 32'(beats_left), 2);
        load(31, 1);
        done_cnt = 0;
        play_enable = 1'b0;
        run(10, 2);
        check("pause_no_done", 32'(done_cnt), 0);
        check("pause_active", 32'(note_active), 0);
`ifdef NOTE_PLAYER_PAUSE_EN
        check("pause_frozen", 32'(beats_left), 2);
`else
        check("abort_beats", 32'(beats_left), 0);
        check("abort_buf_kept", 32'(buf_full), 1);
`endif
        play_enable = 1'b1;
        run(30, 3);
`ifdef NOTE_PLAYER_PAUSE_EN
        check("resume_done_cnt", 32'(done_cnt), 2);
`else
        check("abort_done_cnt", 32'(done_cnt), 1);
`endif
        check("after_pause_note", 32'(note_out), 31);

        // Reset mid-PLAY with buffer full
        load(12, 5);
        tick();
        tick();
        beat = 1'b1; tick(); beat = 1'b0; tick();
        beat = 1'b1; tick(); beat = 1'b0;
        check("rst_pre_beats", 32'(beats_left), 3);
        load(13, 1);
        check("rst_pre_full", 32'(buf_full), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_note", 32'(note_out), 0);
        check("rst_mid_beats", 32'(beats_left), 0);
        check("rst_mid_full", 32'(buf_full), 0);
        check("rst_mid_active", 32'(note_active), 0);
        check("rst_mid_done", 32'(note_done), 0);
        tick();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset         = ($urandom_range(0, 499) == 0);
            play_enable   = ($urandom_range(0, 9) != 0);
            beat          = ($urandom_range(0, 3) == 0);
            load_new_note = ($urandom_range(0, 6) == 0);
            new_note      = ($urandom_range(0, 3) == 0) ? NW'(0) : NW'($urandom);
            new_duration  = ($urandom_range(0, 19) == 0) ? DW'(63) : DW'($urandom_range(0, 5));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
